// File: rtl/mux_arb_rr_pkg.sv
// Shared constants and output-register state encoding for mux_arb_rr.
package mux_arb_rr_pkg;

  localparam int unsigned MUX_ARB_WIDTH = 8;
  localparam int unsigned MUX_ARB_CH    = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/mux_arb_rr_rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr, or fixed lowest-index
// priority when MUX_ARB_FIXED_PRI_EN is defined.
module rr_arbiter #(
  parameter int unsigned CH   = 4,
  parameter int unsigned IDXW = $clog2(CH)
) (
  input  logic [CH-1:0]   req,
  input  logic [IDXW-1:0] ptr,
  output logic [CH-1:0]   grant,
  output logic [IDXW-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

`ifdef MUX_ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = i;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
        found      = 1'b1;
      end
    end
  end
`else
  // Search upward from ptr, wrapping CH-1 -> 0; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < CH; off++) begin
      idx = (32'(ptr) + off) % CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel registered mux with valid/ready handshake and round-robin grant.
// Define MUX_ARB_FIXED_PRI_EN for fixed lowest-index priority (no ptr register).
module mux_arb_rr
  import mux_arb_rr_pkg::*;
#(
  parameter  int unsigned WIDTH = MUX_ARB_WIDTH,
  parameter  int unsigned CH    = MUX_ARB_CH,
  localparam int unsigned IDXW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [IDXW-1:0]     out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  sel_q, sel_d;
  logic [IDXW-1:0]  ptr_cur;
  logic [CH-1:0]    grant;
  logic [IDXW-1:0]  grant_idx;
  logic             load_en;
  logic             xfer;

`ifdef MUX_ARB_FIXED_PRI_EN
  assign ptr_cur = '0;
`else
  logic [IDXW-1:0] ptr_q, ptr_d;
  assign ptr_cur = ptr_q;
`endif

  rr_arbiter #(
    .CH   (CH),
    .IDXW (IDXW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_cur),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign load_en   = !out_valid || out_ready;
  // Gating with rst_n keeps in_ready low throughout reset, not just after the edge.
  assign in_ready  = grant & {CH{load_en & rst_n}};
  assign xfer      = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifndef MUX_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    if (load_en) begin
      if (xfer) begin
        state_d = ST_FULL;
        sel_d   = grant_idx;
        for (int unsigned i = 0; i < CH; i++) begin
          if (grant[i]) data_d = in_data[i*WIDTH +: WIDTH];
        end
`ifndef MUX_ARB_FIXED_PRI_EN
        ptr_d = (grant_idx == IDXW'(CH-1)) ? '0 : grant_idx + 1'b1;
`endif
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
`ifndef MUX_ARB_FIXED_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef MUX_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr (WIDTH=8, CH=4, round-robin build).
module tb_mux_arb_rr;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks;
  int unsigned n_pass;

  mux_arb_rr #(
    .WIDTH (8),
    .CH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a loaded word one cycle after the grant shown on in_ready.
  task automatic xfer_check(input string tag, input logic [3:0] exp_rdy,
                            input logic [7:0] exp_data, input logic [1:0] exp_sel);
    check({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
    step();
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_sel"}, 32'(out_sel), 32'(exp_sel));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid  = 4'hF;
    out_ready = 1'b1;

    #1;
    check("rst_rdy", 32'(in_ready), 32'h0);
    check("rst_vld", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h00);
    step();
    check("rst_hold_rdy", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b1;
    #1;

    // Round-robin over all four channels, wrapping back to 0.
    xfer_check("rr0", 4'b0001, 8'hA0, 2'd0);
    xfer_check("rr1", 4'b0010, 8'hA1, 2'd1);
    xfer_check("rr2", 4'b0100, 8'hA2, 2'd2);
    xfer_check("rr3", 4'b1000, 8'hA3, 2'd3);
    xfer_check("rr4", 4'b0001, 8'hA0, 2'd0);
    xfer_check("rr5", 4'b0010, 8'hA1, 2'd1);

    // ptr is now 2; only channels 1 and 3 request.
    in_valid = 4'b1010;
    #1;
    xfer_check("sp0", 4'b1000, 8'hA3, 2'd3);
    xfer_check("sp1", 4'b0010, 8'hA1, 2'd1);
    xfer_check("sp2", 4'b1000, 8'hA3, 2'd3);

    // Back-pressure while FULL, then drain+load on the same edge.
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    in_data   = {8'hA3, 8'hC2, 8'hA1, 8'hA0};
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", 32'(in_ready), 32'h0);
      step();
      check("bp_data", 32'(out_data), 32'hA3);
      check("bp_vld", 32'(out_valid), 32'd1);
    end
    check("bp_rdy_last", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    xfer_check("bp_load", 4'b0100, 8'hC2, 2'd2);

    // Drain to empty: out_data/out_sel keep their last values.
    in_valid = 4'b0000;
    #1;
    check("dr_rdy", 32'(in_ready), 32'h0);
    step();
    check("dr_vld", 32'(out_valid), 32'd0);
    check("dr_data", 32'(out_data), 32'hC2);
    check("dr_sel", 32'(out_sel), 32'd2);
    step();
    check("dr_idle_vld", 32'(out_valid), 32'd0);

    // ptr is 3; channel 0 wins by wrap and loads 5C, then hold FULL.
    in_data  = {8'hA3, 8'hA2, 8'hA1, 8'h5C};
    in_valid = 4'b0001;
    #1;
    xfer_check("rm_load", 4'b0001, 8'h5C, 2'd0);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check("rm_vld", 32'(out_valid), 32'd0);
    check("rm_data", 32'(out_data), 32'h00);
    check("rm_sel", 32'(out_sel), 32'd0);
    check("rm_rdy", 32'(in_ready), 32'h0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    // ptr was 1 before reset; channel 0 winning shows it restarted at 0.
    xfer_check("rm_first", 4'b0001, 8'h5C, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
